// File: rtl/mem_boot_loader.sv
// Boot loader: takes a 2-byte word-count header and a big-endian byte stream, packs
// bytes into memory words and holds the processor in reset until the image is written.
module mem_boot_loader #(
   parameter int                ADDR_W    = 11,
   parameter int                DATA_W    = 24,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              reload,
   output logic              ld_memwrite,
   output logic [ADDR_W-1:0] ld_address,
   output logic [DATA_W-1:0] ld_writedata,
   output logic              cpu_reset,
   output logic              done
);

   localparam int              BYTES     = DATA_W / 8;
   localparam logic [1:0]      LAST_BYTE = 2'(BYTES - 1);
   localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [3:0]        r_hdr_hi;
   logic [ADDR_W:0]   r_n;
   logic [ADDR_W:0]   r_word_idx;
   logic [1:0]        r_byte_idx;
   logic [DATA_W-1:0] r_word;

   logic              w_accept;
   logic [31:0]       w_hdr_n;
   logic [ADDR_W:0]   w_n;
   logic [ADDR_W:0]   w_word_nxt;
   logic [DATA_W-1:0] w_word_shift;

   assign rx_ready     = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_DATA);
   assign w_accept     = rx_valid & rx_ready;
   // Only the low 12 header bits carry the count; anything beyond the memory depth clamps.
   assign w_hdr_n      = {20'd0, r_hdr_hi, rx_data};
   assign w_n          = (w_hdr_n > 32'(DEPTH)) ? DEPTH : w_hdr_n[ADDR_W:0];
   assign w_word_nxt   = r_word_idx + (ADDR_W + 1)'(1);
   assign w_word_shift = {r_word[DATA_W-9:0], rx_data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_HDR_HI;
         r_hdr_hi     <= '0;
         r_n          <= '0;
         r_word_idx   <= '0;
         r_byte_idx   <= '0;
         r_word       <= '0;
         ld_memwrite  <= 1'b0;
         ld_address   <= '0;
         ld_writedata <= '0;
         cpu_reset    <= 1'b1;
         done         <= 1'b0;
      end else begin
         case (r_state)
            S_HDR_HI: begin
               if (w_accept) begin
                  r_hdr_hi <= rx_data[3:0];
                  r_state  <= S_HDR_LO;
               end
            end
            S_HDR_LO: begin
               if (w_accept) begin
                  r_n        <= w_n;
                  r_word_idx <= '0;
                  r_byte_idx <= '0;
                  if (w_n == '0) begin
                     r_state   <= S_DONE;
                     cpu_reset <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_word <= w_word_shift;
                  if (r_byte_idx == LAST_BYTE) begin
                     // Strobe is registered here so it is high for exactly the S_WRITE cycle.
                     r_byte_idx   <= '0;
                     ld_memwrite  <= 1'b1;
                     ld_address   <= BASE_ADDR + r_word_idx[ADDR_W-1:0];
                     ld_writedata <= w_word_shift;
                     r_state      <= S_WRITE;
                  end else begin
                     r_byte_idx <= r_byte_idx + 2'd1;
                  end
               end
            end
            S_WRITE: begin
               ld_memwrite <= 1'b0;
               r_word_idx  <= w_word_nxt;
               if (w_word_nxt == r_n) begin
                  r_state   <= S_DONE;
                  cpu_reset <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  r_state <= S_DATA;
               end
            end
            S_DONE: begin
               if (reload) begin
                  r_state    <= S_HDR_HI;
                  r_word_idx <= '0;
                  r_byte_idx <= '0;
                  cpu_reset  <= 1'b1;
                  done       <= 1'b0;
               end
            end
            default: r_state <= S_HDR_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: two instances (BASE_ADDR 0 and 5) share one
// upstream stream; a write monitor records what each would store in memory.
module tb_mem_boot_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        reload = 1'b0;

   logic        rx_ready0, ld_memwrite0, cpu_reset0, done0;
   logic [10:0] ld_address0;
   logic [23:0] ld_writedata0;
   logic        rx_ready5, ld_memwrite5, cpu_reset5, done5;
   logic [10:0] ld_address5;
   logic [23:0] ld_writedata5;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wcnt0, wcnt5, rdy_viol;
   logic [10:0] last0, last5;
   logic [23:0] mem0 [2048];
   logic [23:0] mem5 [2048];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_boot_loader #(.ADDR_W(11), .DATA_W(24), .BASE_ADDR(11'd0)) dut0 (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready0), .reload(reload), .ld_memwrite(ld_memwrite0),
      .ld_address(ld_address0), .ld_writedata(ld_writedata0),
      .cpu_reset(cpu_reset0), .done(done0));

   mem_boot_loader #(.ADDR_W(11), .DATA_W(24), .BASE_ADDR(11'd5)) dut5 (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready5), .reload(reload), .ld_memwrite(ld_memwrite5),
      .ld_address(ld_address5), .ld_writedata(ld_writedata5),
      .cpu_reset(cpu_reset5), .done(done5));

   always @(negedge clk) begin
      if (!reset) begin
         if (ld_memwrite0) begin
            mem0[ld_address0] = ld_writedata0;
            last0 = ld_address0;
            wcnt0++;
            if (rx_ready0) rdy_viol++;
         end
         if (ld_memwrite5) begin
            mem5[ld_address5] = ld_writedata5;
            last5 = ld_address5;
            wcnt5++;
         end
      end
   end

   task automatic clear_mon();
      wcnt0 = 0; wcnt5 = 0; rdy_viol = 0; last0 = '0; last5 = '0;
      for (int i = 0; i < 2048; i++) begin
         mem0[i] = '0;
         mem5[i] = '0;
      end
   endtask

   task automatic do_reset();
      rx_valid = 1'b0; reload = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      clear_mon();
   endtask

   // Present one byte (after 'idle' empty cycles) and return 1 ns after the edge that takes it.
   task automatic send_byte(input logic [7:0] b, input int idle);
      bit ok = 0;
      if (idle > 0) begin
         rx_valid = 1'b0;
         rx_data = 8'($urandom);
         repeat (idle) @(posedge clk);
         #1;
      end
      rx_valid = 1'b1;
      rx_data = b;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rx_ready0) begin
            @(posedge clk); #1;
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout byte=%h not accepted within 20 cycles", b);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_valid = 1'b0; reload = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (cpu_reset0 !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done0); end
      checks++; if (ld_memwrite0 !== 1'b0) begin errors++; $display("FAIL rst_memwrite got %b exp 0", ld_memwrite0); end
      checks++; if (ld_address0 !== 11'd0) begin errors++; $display("FAIL rst_address got %h exp 000", ld_address0); end
      checks++; if (ld_writedata0 !== 24'd0) begin errors++; $display("FAIL rst_writedata got %h exp 000000", ld_writedata0); end
      checks++; if (rx_ready0 !== 1'b1) begin errors++; $display("FAIL rst_rx_ready got %b exp 1", rx_ready0); end
      @(posedge clk); #1;
      reset = 1'b0;
      clear_mon();
   endtask

   task automatic test_two_words();
      int c0;
      do_reset();
      send_byte(8'h00, 0);
      c0 = cyc;
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      checks++; if (ld_memwrite0 !== 1'b1) begin errors++; $display("FAIL w0_strobe got %b exp 1", ld_memwrite0); end
      checks++; if (ld_address0 !== 11'd0) begin errors++; $display("FAIL w0_addr got %h exp 000", ld_address0); end
      checks++; if (ld_writedata0 !== 24'h112233) begin errors++; $display("FAIL w0_data got %h exp 112233", ld_writedata0); end
      checks++; if (rx_ready0 !== 1'b0) begin errors++; $display("FAIL w0_ready got %b exp 0", rx_ready0); end
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      rx_valid = 1'b0;
      checks++; if (ld_writedata0 !== 24'h445566 || ld_address0 !== 11'd1) begin errors++; $display("FAIL w1_write got %h@%h exp 445566@001", ld_writedata0, ld_address0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL w1_early_done got %b exp 0", done0); end
      @(posedge clk); #1;
      checks++; if (done0 !== 1'b1 || cpu_reset0 !== 1'b0) begin errors++; $display("FAIL s1_done got done=%b cpu_reset=%b exp 1/0", done0, cpu_reset0); end
      checks++; if (cyc - c0 !== 9) begin errors++; $display("FAIL s1_latency got %0d exp 9 edges after first accept", cyc - c0); end
      checks++; if (ld_memwrite0 !== 1'b0 || ld_writedata0 !== 24'h445566) begin errors++; $display("FAIL s1_hold got we=%b data=%h exp 0/445566", ld_memwrite0, ld_writedata0); end
      checks++; if (wcnt0 !== 2) begin errors++; $display("FAIL s1_wcount got %0d exp 2", wcnt0); end
   endtask

   task automatic test_zero_len();
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      rx_valid = 1'b0;
      checks++; if (done0 !== 1'b1 || cpu_reset0 !== 1'b0 || rx_ready0 !== 1'b0) begin errors++; $display("FAIL zero_done got done=%b cpu=%b rdy=%b exp 1/0/0", done0, cpu_reset0, rx_ready0); end
      repeat (5) @(posedge clk); #1;
      checks++; if (wcnt0 !== 0) begin errors++; $display("FAIL zero_writes got %0d exp 0", wcnt0); end
   endtask

   task automatic test_clamp_wrap();
      do_reset();
      send_byte(8'h0F, 0);
      send_byte(8'hFF, 0);
      for (int i = 0; i < 2048; i++)
         for (int j = 0; j < 3; j++)
            send_byte(8'(3 * i + j), 0);
      rx_valid = 1'b0;
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL clamp_early_done got %b exp 0", done0); end
      @(posedge clk); #1;
      checks++; if (done0 !== 1'b1 || done5 !== 1'b1) begin errors++; $display("FAIL clamp_done got %b/%b exp 1/1", done0, done5); end
      checks++; if (wcnt0 !== 2048 || wcnt5 !== 2048) begin errors++; $display("FAIL clamp_wcount got %0d/%0d exp 2048/2048", wcnt0, wcnt5); end
      checks++; if (last5 !== 11'd4) begin errors++; $display("FAIL wrap_last_addr got %h exp 004", last5); end
      checks++; if (last0 !== 11'd2047) begin errors++; $display("FAIL base0_last_addr got %h exp 7ff", last0); end
      checks++; if (mem5[4] !== 24'hFDFEFF || mem5[5] !== 24'h000102) begin errors++; $display("FAIL wrap_data got %h %h exp fdfeff 000102", mem5[4], mem5[5]); end
      checks++; if (mem0[2047] !== 24'hFDFEFF) begin errors++; $display("FAIL base0_last_data got %h exp fdfeff", mem0[2047]); end
   endtask

   task automatic test_random_valid();
      logic [7:0] bytes [8];
      bytes = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      do_reset();
      for (int i = 0; i < 8; i++) send_byte(bytes[i], int'($urandom_range(0, 2)));
      rx_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (mem0[0] !== 24'h112233 || mem0[1] !== 24'h445566) begin errors++; $display("FAIL rnd_mem got %h %h exp 112233 445566", mem0[0], mem0[1]); end
      checks++; if (wcnt0 !== 2 || done0 !== 1'b1) begin errors++; $display("FAIL rnd_done got writes=%0d done=%b exp 2/1", wcnt0, done0); end
      checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL rnd_ready_in_write got %0d exp 0", rdy_viol); end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      send_byte(8'h00, 0); send_byte(8'h02, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      send_byte(8'h44, 0); send_byte(8'h55, 0);
      rx_valid = 1'b0;
      reset = 1'b1;
      #1;
      checks++; if (ld_writedata0 !== 24'd0 || ld_address0 !== 11'd0 || ld_memwrite0 !== 1'b0) begin errors++; $display("FAIL mid_rst_data got %h@%h we=%b exp 000000@000 0", ld_writedata0, ld_address0, ld_memwrite0); end
      checks++; if (cpu_reset0 !== 1'b1 || done0 !== 1'b0 || rx_ready0 !== 1'b1) begin errors++; $display("FAIL mid_rst_ctrl got cpu=%b done=%b rdy=%b exp 1/0/1", cpu_reset0, done0, rx_ready0); end
      checks++; if (wcnt0 !== 1) begin errors++; $display("FAIL mid_rst_partial got %0d writes exp 1", wcnt0); end
      @(posedge clk); #1;
      reset = 1'b0;
      clear_mon();
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
      rx_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (wcnt0 !== 1 || mem0[0] !== 24'hAABBCC) begin errors++; $display("FAIL reload1_write got %0d x %h exp 1 x aabbcc", wcnt0, mem0[0]); end
      checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL reload1_done got %b exp 1", done0); end
   endtask

   task automatic test_done_reload();
      int stalls = 0;
      rx_valid = 1'b1; rx_data = 8'h77;
      repeat (5) begin
         @(negedge clk);
         if (rx_ready0 !== 1'b0) stalls++;
      end
      @(posedge clk); #1;
      checks++; if (stalls !== 0 || done0 !== 1'b1 || wcnt0 !== 1) begin errors++; $display("FAIL done_surplus got ready_hi=%0d done=%b writes=%0d exp 0/1/1", stalls, done0, wcnt0); end
      rx_valid = 1'b0; reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
      checks++; if (cpu_reset0 !== 1'b1 || done0 !== 1'b0 || rx_ready0 !== 1'b1) begin errors++; $display("FAIL reload_ctrl got cpu=%b done=%b rdy=%b exp 1/0/1", cpu_reset0, done0, rx_ready0); end
      clear_mon();
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
      rx_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (wcnt0 !== 1 || mem0[0] !== 24'h123456 || done0 !== 1'b1) begin errors++; $display("FAIL reload2 got %0d x %h done=%b exp 1 x 123456 1", wcnt0, mem0[0], done0); end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_two_words();
      test_zero_len();
      test_clamp_wrap();
      test_random_valid();
      test_reset_mid_load();
      test_done_reload();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
